// File: rtl/turbo_itl_pkg.sv
// turbo_itl_pkg: shared types and constants for the turbo interleaver
// controller (FSM state encoding, default address width).
package turbo_itl_pkg;

  localparam int ITL_A_WIDTH = 16;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FILL  = 2'd1,
    S_DRAIN = 2'd2,
    S_FLUSH = 2'd3
  } itl_state_t;

endpackage

// File: rtl/itl_skid_fifo.sv
// itl_skid_fifo: small synchronous FIFO holding {sys, itl, last} pairs
// between the RAM read pipeline and the throttled output stream.
module itl_skid_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 3,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [W-1:0]  wdata,
  input  logic          pop,
  output logic [W-1:0]  rdata,
  output logic          empty,
  output logic [CW-1:0] count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          do_push, do_pop;

  assign do_push = push && (cnt_q != CW'(DEPTH));
  assign do_pop  = pop && (cnt_q != '0);

  // pointer and occupancy update
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (do_push) begin
      wptr_d = (wptr_q == PW'(DEPTH - 1)) ? '0 : wptr_q + PW'(1);
    end
    if (do_pop) begin
      rptr_d = (rptr_q == PW'(DEPTH - 1)) ? '0 : rptr_q + PW'(1);
    end
    unique case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // pointer/count registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  // storage needs no reset; occupancy gates visibility
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wptr_q] <= wdata;
    end
  end

  assign rdata = mem_q[rptr_q];
  assign empty = (cnt_q == '0);
  assign count = cnt_q;

endmodule

// File: rtl/turbo_itl_ctrl.sv
// turbo_itl_ctrl: fills a bit RAM with a K-bit block, then reads it back as
// natural/interleaved pairs. TURBO_ITL_CTRL_BACKPRESSURE_EN adds a skid FIFO.
module turbo_itl_ctrl
  import turbo_itl_pkg::*;
#(
  parameter int A_WIDTH    = ITL_A_WIDTH,
  parameter int FIFO_DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [A_WIDTH-1:0] blk_len,
  input  logic [A_WIDTH-1:0] jump,
  input  logic               in_valid,
  input  logic               in_data,
  output logic               in_ready,
  output logic               ram_wen,
  output logic [A_WIDTH-1:0] ram_waddr,
  output logic               ram_wdata,
  output logic [A_WIDTH-1:0] ram_id_jump,
  input  logic               ram_rdata,
  input  logic               ram_rdata_itl,
  output logic               out_valid,
  output logic               out_sys,
  output logic               out_itl,
  output logic               out_last,
  input  logic               out_ready,
  output logic               busy,
  output logic               done
);

  localparam logic [A_WIDTH-1:0] ONE = A_WIDTH'(1);

  itl_state_t         state_q, state_d;
  logic [A_WIDTH-1:0] cnt_q, cnt_d;
  logic [A_WIDTH-1:0] k_q, k_d;
  logic [A_WIDTH-1:0] jump_q, jump_d;
  logic [A_WIDTH-1:0] waddr_q, waddr_d;
  logic               v1_q, v1_d, v2_q, v2_d;
  logic               l1_q, l1_d, l2_q, l2_d;
  logic               wen, issue, at_last, can_issue;
  logic               pop, pop_last;

  assign at_last = (cnt_q == k_q - ONE);

`ifdef TURBO_ITL_CTRL_BACKPRESSURE_EN
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  logic [2:0]    fifo_rdata;
  logic          fifo_empty;
  logic [CW-1:0] fifo_cnt;

  itl_skid_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (3),
    .CW    (CW)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (v2_q),
    .wdata ({ram_rdata, ram_rdata_itl, l2_q}),
    .pop   (pop),
    .rdata (fifo_rdata),
    .empty (fifo_empty),
    .count (fifo_cnt)
  );

  assign can_issue = (32'(fifo_cnt) + 32'(v1_q) + 32'(v2_q))
                     < 32'(FIFO_DEPTH);
  assign out_valid = !fifo_empty;
  assign pop       = out_valid && out_ready;
  assign pop_last  = fifo_rdata[0];
  assign out_sys   = fifo_rdata[2];
  assign out_itl   = fifo_rdata[1];
  assign out_last  = out_valid && fifo_rdata[0];
`else
  logic unused_out_ready;

  assign unused_out_ready = out_ready;
  assign can_issue = 1'b1;
  assign out_valid = v2_q;
  assign pop       = v2_q;
  assign pop_last  = l2_q;
  assign out_sys   = ram_rdata;
  assign out_itl   = ram_rdata_itl;
  assign out_last  = v2_q && l2_q;
`endif

  // next-state, counter and RAM port control
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    k_d     = k_q;
    jump_d  = jump_q;
    wen     = 1'b0;
    issue   = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start && (blk_len != '0)) begin
          k_d     = blk_len;
          jump_d  = jump;
          cnt_d   = '0;
          state_d = S_FILL;
        end
      end
      S_FILL: begin
        if (in_valid) begin
          wen = 1'b1;
          if (at_last) begin
            cnt_d   = '0;
            state_d = S_DRAIN;
          end else begin
            cnt_d = cnt_q + ONE;
          end
        end
      end
      S_DRAIN: begin
        if (can_issue) begin
          issue = 1'b1;
          if (at_last) begin
            state_d = S_FLUSH;
          end else begin
            cnt_d = cnt_q + ONE;
          end
        end
      end
      S_FLUSH: begin
        if (pop && pop_last) begin
          done    = 1'b1;
          state_d = S_IDLE;
        end
      end
    endcase
  end

  // read-data alignment pipeline and held address
  always_comb begin
    v1_d    = issue;
    l1_d    = issue && at_last;
    v2_d    = v1_q;
    l2_d    = l1_q;
    waddr_d = (wen || issue) ? cnt_q : waddr_q;
  end

  // state and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      k_q     <= '0;
      jump_q  <= '0;
      waddr_q <= '0;
      v1_q    <= 1'b0;
      v2_q    <= 1'b0;
      l1_q    <= 1'b0;
      l2_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      k_q     <= k_d;
      jump_q  <= jump_d;
      waddr_q <= waddr_d;
      v1_q    <= v1_d;
      v2_q    <= v2_d;
      l1_q    <= l1_d;
      l2_q    <= l2_d;
    end
  end

  assign in_ready    = (state_q == S_FILL);
  assign ram_wen     = wen;
  assign ram_waddr   = waddr_d;
  assign ram_wdata   = wen && in_data;
  assign ram_id_jump = jump_q;
  assign busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_turbo_itl_ctrl.sv
// tb_turbo_itl_ctrl: scoreboard bench; the bench acts as the dual-read RAM
// (2-cycle latency, interleaved address = (addr + jump) mod K).
module tb_turbo_itl_ctrl;

`ifdef TURBO_ITL_CTRL_BACKPRESSURE_EN
  localparam bit BP = 1'b1;
`else
  localparam bit BP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] blk_len, jump;
  logic        in_valid, in_data, in_ready;
  logic        ram_wen, ram_wdata;
  logic [15:0] ram_waddr, ram_id_jump;
  logic        ram_rdata, ram_rdata_itl;
  logic        out_valid, out_sys, out_itl, out_last, out_ready;
  logic        busy, done;

  turbo_itl_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .blk_len       (blk_len),
    .jump          (jump),
    .in_valid      (in_valid),
    .in_data       (in_data),
    .in_ready      (in_ready),
    .ram_wen       (ram_wen),
    .ram_waddr     (ram_waddr),
    .ram_wdata     (ram_wdata),
    .ram_id_jump   (ram_id_jump),
    .ram_rdata     (ram_rdata),
    .ram_rdata_itl (ram_rdata_itl),
    .out_valid     (out_valid),
    .out_sys       (out_sys),
    .out_itl       (out_itl),
    .out_last      (out_last),
    .out_ready     (out_ready),
    .busy          (busy),
    .done          (done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  logic       ram_mem [0:65535];
  logic       rd1, rd2, ri1, ri2;
  int         cur_k = 1;
  logic [2:0] exp_q [$];
  logic       blk_bits [0:1023];
  int         exp_waddr, wr_cnt, pop_cnt, done_cnt, busy_drop;
  bit         blk_on = 1'b0;
  bit         throttle = 1'b0;
  int         phase = 0;

  // RAM model: write port plus two reads with 2-cycle latency
  always @(posedge clk) begin
    if (ram_wen) ram_mem[ram_waddr] <= ram_wdata;
    rd1 <= ram_mem[ram_waddr];
    ri1 <= ram_mem[16'((int'(ram_waddr) + int'(ram_id_jump)) % cur_k)];
    rd2 <= rd1;
    ri2 <= ri1;
  end
  assign ram_rdata     = rd2;
  assign ram_rdata_itl = ri2;

  // output ready: one cycle in three when throttled
  always @(posedge clk) begin
    #1;
    phase = (phase + 1) % 3;
    out_ready = throttle ? (phase == 0) : 1'b1;
  end

  // monitor: writes, popped pairs, done alignment, busy level
  always @(negedge clk) begin
    logic [2:0] e;
    logic       popping;
    popping = out_valid && (out_ready || !BP);
    if (ram_wen) begin
      check("waddr", ram_waddr, exp_waddr);
      check("wdata", ram_wdata, blk_bits[exp_waddr % 1024]);
      exp_waddr++;
      wr_cnt++;
    end
    if (popping) begin
      if (exp_q.size() == 0) begin
        check("pop_unexp", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("pair", {out_sys, out_itl, out_last}, e);
      end
      pop_cnt++;
    end
    if (done || (popping && out_last))
      check("done_at_last", done, popping && out_last);
    if (blk_on && !busy) busy_drop++;
    if (done) begin
      done_cnt++;
      blk_on = 1'b0;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic begin_block(input int k, input int jmp);
    cur_k = k;
    for (int i = 0; i < k; i++) blk_bits[i] = 1'($urandom);
    for (int i = 0; i < k; i++)
      exp_q.push_back({blk_bits[i], blk_bits[(i + jmp) % k], i == k - 1});
    exp_waddr = 0;
    wr_cnt = 0;
    pop_cnt = 0;
    done_cnt = 0;
    busy_drop = 0;
    start = 1'b1;
    blk_len = 16'(k);
    jump = 16'(jmp);
    step();
    start = 1'b0;
    blk_len = 16'($urandom);
    jump = 16'($urandom);
    blk_on = 1'b1;
    check("busy_on", busy, 1);
  endtask

  task automatic run_block(input int k, input int jmp, input bit thr,
                           input bit mid_start);
    int n;
    throttle = thr;
    begin_block(k, jmp);
    for (int i = 0; i < k; i++) begin
      while ($urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        step();
      end
      in_valid = 1'b1;
      in_data = blk_bits[i];
      step();
    end
    in_valid = 1'b0;
    check("rdy_drop", in_ready, 0);
    if (mid_start) begin
      step();
      step();
      start = 1'b1;
      blk_len = 16'd8;
      step();
      start = 1'b0;
    end
    n = 0;
    while (done_cnt == 0 && n < 5000) begin
      step();
      n++;
    end
    check("done_timeout", n < 5000, 1);
    repeat (6) step();
    check("done_cnt", done_cnt, 1);
    check("wr_cnt", wr_cnt, k);
    check("pop_cnt", pop_cnt, k);
    check("q_empty", exp_q.size(), 0);
    check("busy_off", busy, 0);
    check("busy_held", busy_drop, 0);
    throttle = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    blk_len = '0;
    jump = '0;
    in_valid = 1'b0;
    in_data = 1'b0;
    out_ready = 1'b1;
    repeat (2) step();
    check("rst_flags",
          {in_ready, ram_wen, out_valid, out_last, busy, done}, 0);
    check("rst_waddr", ram_waddr, 0);
    check("rst_jump", ram_id_jump, 0);
    rst = 1'b0;
    step();

    run_block(40, 0, 1'b0, 1'b0);
    run_block(1, 0, 1'b0, 1'b0);
    run_block(64, 5, 1'b1, 1'b0);
    run_block(20, 7, 1'b0, 1'b1);
    run_block(33, 31, 1'b1, 1'b0);

    // abort on reset while bit 17 of a 100-bit block is offered
    throttle = 1'b0;
    begin_block(100, 9);
    for (int i = 0; i < 17; i++) begin
      in_valid = 1'b1;
      in_data = blk_bits[i];
      step();
    end
    in_data = blk_bits[17];
    blk_on = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_flags",
          {in_ready, ram_wen, out_valid, out_last, busy, done}, 0);
    check("mid_rst_waddr", ram_waddr, 0);
    check("mid_rst_jump", ram_id_jump, 0);
    in_valid = 1'b0;
    step();
    rst = 1'b0;
    check("wr_before_rst", wr_cnt, 17);
    exp_q.delete();
    step();
    run_block(10, 3, 1'b0, 1'b0);

    // zero-length start is ignored
    wr_cnt = 0;
    start = 1'b1;
    blk_len = '0;
    jump = 16'd4;
    in_valid = 1'b1;
    step();
    start = 1'b0;
    check("zero_busy", busy, 0);
    repeat (4) step();
    in_valid = 1'b0;
    check("zero_busy_late", busy, 0);
    check("zero_rdy", in_ready, 0);
    check("zero_wr", wr_cnt, 0);
    check("zero_jump", ram_id_jump, 16'd3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
